// File: rtl/uart_fifo_controller.sv
// UART with configurable frame format, 16x-oversampled receiver and TX/RX byte FIFOs.
// Each received byte is stored in the RX FIFO together with its parity and framing error flags.
module uart_fifo_controller #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              receive_uart,
    output logic                              transmit_uart,
    input  logic [DATA_BITS-1:0]              transmit_data,
    input  logic                              transmit_valid,
    output logic                              transmit_ready,
    output logic [DATA_BITS-1:0]              receive_data,
    output logic                              receive_parity_error,
    output logic                              receive_frame_error,
    output logic                              receive_valid,
    input  logic                              receive_ready,
    output logic                              receive_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   transmit_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   receive_count
);
    localparam int DIV_RAW  = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIVISOR  = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BIT_CLKS = DIVISOR * OVERSAMPLE;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int DVW      = $clog2(DIVISOR + 1);
    localparam int OSW      = $clog2(OVERSAMPLE);
    localparam int BCW      = $clog2(BIT_CLKS);
    localparam int EW       = DATA_BITS + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        parity_bit = (PARITY == 2) ? ~^d : ^d;
    endfunction

    // ---------------- receiver ----------------
    logic                 rx_meta, rx_sync;
    logic [DVW-1:0]       rx_div;
    logic                 rx_tick;
    logic [OSW-1:0]       rx_os;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_perr;
    logic [2:0]           rx_state;
    logic                 rx_push;
    logic                 rx_last_os;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= receive_uart;
            rx_sync <= rx_meta;
        end
    end

    assign rx_tick    = (rx_div == DVW'(DIVISOR - 1));
    assign rx_last_os = (rx_os == OSW'(OVERSAMPLE - 1));
    assign rx_push    = (rx_state == S_STOP) && rx_tick && rx_last_os;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state <= S_IDLE;
            rx_div   <= '0;
            rx_os    <= '0;
            rx_bit   <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_div <= rx_tick ? '0 : rx_div + DVW'(1);
            case (rx_state)
                S_IDLE: begin
                    // Tick phase restarts on the start edge so samples land mid-bit
                    rx_div  <= '0;
                    rx_os   <= '0;
                    rx_perr <= 1'b0;
                    if (!rx_sync) rx_state <= S_START;
                end
                S_START: if (rx_tick) begin
                    if (rx_os == OSW'(OVERSAMPLE / 2 - 1)) begin
                        rx_os    <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_os <= rx_os + OSW'(1);
                    end
                end
                S_DATA: if (rx_tick) begin
                    if (rx_last_os) begin
                        rx_os    <= '0;
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == 4'(DATA_BITS - 1))
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            rx_bit <= rx_bit + 4'd1;
                    end else begin
                        rx_os <= rx_os + OSW'(1);
                    end
                end
                S_PARITY: if (rx_tick) begin
                    if (rx_last_os) begin
                        rx_os    <= '0;
                        rx_perr  <= (rx_sync != parity_bit(rx_shift));
                        rx_state <= S_STOP;
                    end else begin
                        rx_os <= rx_os + OSW'(1);
                    end
                end
                S_STOP: if (rx_tick) begin
                    if (rx_last_os) begin
                        rx_os    <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_BREAK;
                    end else begin
                        rx_os <= rx_os + OSW'(1);
                    end
                end
                S_BREAK: if (rx_sync) rx_state <= S_IDLE;
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO: {frame_err, parity_err, data} ----------------
    logic [EW-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr, rx_rd;
    logic [CW-1:0] rx_fill;
    logic          rx_full, rx_empty, rx_wr_en, rx_rd_en;
    logic [EW-1:0] rx_head;

    assign rx_full  = (rx_fill == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_fill == '0);
    assign rx_wr_en = rx_push && !rx_full;
    assign rx_rd_en = !rx_empty && receive_ready;
    assign rx_head  = rx_mem[rx_rd];

    always_ff @(posedge clock) begin
        if (rx_wr_en) rx_mem[rx_wr] <= {~rx_sync, rx_perr, rx_shift};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_wr           <= '0;
            rx_rd           <= '0;
            rx_fill         <= '0;
            receive_overrun <= 1'b0;
        end else begin
            if (rx_wr_en) rx_wr <= rx_wr + AW'(1);
            if (rx_rd_en) rx_rd <= rx_rd + AW'(1);
            rx_fill <= rx_fill + CW'(rx_wr_en) - CW'(rx_rd_en);
            if (rx_push && rx_full) receive_overrun <= 1'b1;
        end
    end

    assign receive_valid        = !rx_empty;
    assign receive_data         = rx_empty ? '0 : rx_head[DATA_BITS-1:0];
    assign receive_parity_error = !rx_empty && rx_head[DATA_BITS];
    assign receive_frame_error  = !rx_empty && rx_head[DATA_BITS+1];
    assign receive_count        = rx_fill;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr, tx_rd;
    logic [CW-1:0]        tx_fill;
    logic                 tx_full, tx_empty, tx_wr_en, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_full        = (tx_fill == CW'(FIFO_DEPTH));
    assign tx_empty       = (tx_fill == '0);
    assign transmit_ready = !tx_full && reset;
    assign tx_wr_en       = transmit_valid && transmit_ready;
    assign tx_head        = tx_mem[tx_rd];
    assign transmit_count = tx_fill;

    always_ff @(posedge clock) begin
        if (tx_wr_en) tx_mem[tx_wr] <= transmit_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_wr   <= '0;
            tx_rd   <= '0;
            tx_fill <= '0;
        end else begin
            if (tx_wr_en) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)   tx_rd <= tx_rd + AW'(1);
            tx_fill <= tx_fill + CW'(tx_wr_en) - CW'(tx_pop);
        end
    end

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [BCW-1:0]       tx_timer;
    logic                 tx_end;
    logic [3:0]           tx_bit;
    logic                 tx_stop_n;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_line;

    assign tx_end = (tx_timer == BCW'(BIT_CLKS - 1));
    // Back-to-back frames: the next byte is popped on the last cycle of the final stop bit
    assign tx_pop = !tx_empty && ((tx_state == S_IDLE) ||
                    (tx_state == S_STOP && tx_end && tx_stop_n == 1'(STOP_BITS - 1)));
    assign transmit_uart = tx_line;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state  <= S_IDLE;
            tx_timer  <= '0;
            tx_bit    <= '0;
            tx_stop_n <= 1'b0;
            tx_line   <= 1'b1;
        end else begin
            if (tx_state != S_IDLE) tx_timer <= tx_end ? '0 : tx_timer + BCW'(1);
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_par   <= parity_bit(tx_head);
                tx_line  <= 1'b0;
                tx_timer <= '0;
                tx_state <= S_START;
            end else begin
                case (tx_state)
                    S_START: if (tx_end) begin
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end
                    S_DATA: if (tx_end) begin
                        if (tx_bit == 4'(DATA_BITS - 1)) begin
                            tx_stop_n <= 1'b0;
                            if (PARITY != 0) begin
                                tx_line  <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 4'd1;
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                    S_PARITY: if (tx_end) begin
                        tx_line   <= 1'b1;
                        tx_stop_n <= 1'b0;
                        tx_state  <= S_STOP;
                    end
                    S_STOP: if (tx_end) begin
                        if (tx_stop_n == 1'(STOP_BITS - 1)) tx_state <= S_IDLE;
                        else tx_stop_n <= tx_stop_n + 1'b1;
                    end
                    S_IDLE: tx_line <= 1'b1;
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller: 8N1 instance for RX/TX/FIFO behaviour,
// 8E1 instance for parity error detection. 16 clocks per bit, FIFO depth 4.
module tb_uart_fifo_controller;
    localparam int CF = 1600, BR = 100, OS = 16, DEPTH = 4, CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          rx_a = 1'b1, txd_a, tx_valid_a = 1'b0, tx_ready_a, pe_a, fe_a, rv_a, rr_a = 1'b0, ov_a;
    logic [7:0]    tx_data_a = '0, rx_data_a;
    logic [CW-1:0] tc_a, rc_a;
    logic          rx_b = 1'b1, txd_b, tx_valid_b = 1'b0, tx_ready_b, pe_b, fe_b, rv_b, rr_b = 1'b0, ov_b;
    logic [7:0]    tx_data_b = '0, rx_data_b;
    logic [CW-1:0] tc_b, rc_b;

    uart_fifo_controller #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut (
        .clock(clk), .reset(rst_n), .receive_uart(rx_a), .transmit_uart(txd_a),
        .transmit_data(tx_data_a), .transmit_valid(tx_valid_a), .transmit_ready(tx_ready_a),
        .receive_data(rx_data_a), .receive_parity_error(pe_a), .receive_frame_error(fe_a),
        .receive_valid(rv_a), .receive_ready(rr_a), .receive_overrun(ov_a),
        .transmit_count(tc_a), .receive_count(rc_a));

    uart_fifo_controller #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_par (
        .clock(clk), .reset(rst_n), .receive_uart(rx_b), .transmit_uart(txd_b),
        .transmit_data(tx_data_b), .transmit_valid(tx_valid_b), .transmit_ready(tx_ready_b),
        .receive_data(rx_data_b), .receive_parity_error(pe_b), .receive_frame_error(fe_b),
        .receive_valid(rv_b), .receive_ready(rr_b), .receive_overrun(ov_b),
        .transmit_count(tc_b), .receive_count(rc_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int sel, input logic b, input int n);
        if (sel == 0) rx_a = b;
        else rx_b = b;
        tick(n);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                              input logic pbit, input logic stopv, input int stop_clks);
        send_bit(sel, 1'b0, OS);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], OS);
        if (use_par) send_bit(sel, pbit, OS);
        send_bit(sel, stopv, stop_clks);
    endtask

    task automatic pop(input int sel);
        if (sel == 0) rr_a = 1'b1;
        else rr_b = 1'b1;
        tick(1);
        rr_a = 1'b0;
        rr_b = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    logic       samp [330];
    logic [7:0] vals [5];
    logic [7:0] d;
    logic       e;
    logic [CW-1:0] c8, c170;
    int w, f, k;

    initial begin
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
        #1;
        tick(3);
        check("rst_txd", txd_a, 1);
        check("rst_tx_ready", tx_ready_a, 0);
        check("rst_rx_valid", rv_a, 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_tc", tc_a, 0);
        check("rst_rc", rc_a, 0);
        check("rst_ov", ov_a, 0);
        rst_n = 1'b1;
        tick(2);
        check("tx_ready_after_rst", tx_ready_a, 1);

        // receive AA 8N1, checked shortly after the mid-stop sample
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 14);
        check("t1_valid", rv_a, 1);
        check("t1_data", rx_data_a, 8'hAA);
        check("t1_pe", pe_a, 0);
        check("t1_fe", fe_a, 0);
        check("t1_count", rc_a, 1);
        tick(2);
        pop(0);
        check("t1_pop_valid", rv_a, 0);
        check("t1_pop_count", rc_a, 0);

        // framing error followed by a long low line
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 48);
        check("t4_count", rc_a, 1);
        check("t4_data", rx_data_a, 8'h3C);
        check("t4_fe", fe_a, 1);
        check("t4_pe", pe_a, 0);
        send_bit(0, 1'b1, OS);
        check("t4_no_extra", rc_a, 1);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, OS);
        check("t4_count2", rc_a, 2);
        check("t4_head_held", rx_data_a, 8'h3C);
        pop(0);
        check("t4_data2", rx_data_a, 8'h81);
        check("t4_fe2", fe_a, 0);
        pop(0);
        check("t4_empty", rv_a, 0);

        // overrun with receive_ready held low
        for (int i = 0; i < 5; i++) begin
            send_frame(0, vals[i], 1'b0, 1'b0, 1'b1, OS);
            if (i == 3) check("t5_no_ov_yet", ov_a, 0);
        end
        check("t5_count", rc_a, 4);
        check("t5_ov", ov_a, 1);
        for (int i = 0; i < 4; i++) begin
            check("t5_order", rx_data_a, {24'd0, vals[i]});
            pop(0);
        end
        check("t5_drained", rc_a, 0);

        // two back-to-back TX frames
        tx_data_a = 8'h55; tx_valid_a = 1'b1;
        tick(1);
        tx_data_a = 8'h0F;
        tick(1);
        tx_valid_a = 1'b0;
        w = 0;
        while (txd_a !== 1'b0 && w < 10) begin
            tick(1);
            w++;
        end
        check("t2_start_seen", (w < 10), 1);
        for (int i = 0; i < 330; i++) begin
            samp[i] = txd_a;
            if (i == 8) c8 = tc_a;
            if (i == 170) c170 = tc_a;
            tick(1);
        end
        for (int b = 0; b < 20; b++) begin
            f = b / 10;
            k = b % 10;
            d = (f == 1) ? 8'h0F : 8'h55;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
            check($sformatf("t2_bit%0d_first", b), samp[b*16], e);
            check($sformatf("t2_bit%0d_mid", b), samp[b*16+8], e);
            check($sformatf("t2_bit%0d_last", b), samp[b*16+15], e);
        end
        check("t2_idle_after", samp[325], 1);
        check("t2_tc_frame1", c8, 1);
        check("t2_tc_frame2", c170, 0);

        // even parity receiver
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, OS);
        check("t3_valid", rv_b, 1);
        check("t3_data", rx_data_b, 8'h07);
        check("t3_pe", pe_b, 1);
        check("t3_fe", fe_b, 0);
        pop(1);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, OS);
        check("t3_data_ok", rx_data_b, 8'h07);
        check("t3_pe_ok", pe_b, 0);
        pop(1);
        check("t3_empty", rc_b, 0);

        // reset in the middle of a TX frame with RX byte pending and overrun set
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, OS);
        check("t6_pre_rc", rc_a, 1);
        check("t6_pre_ov", ov_a, 1);
        tx_data_a = 8'hAA; tx_valid_a = 1'b1;
        tick(1);
        tx_valid_a = 1'b0;
        tick(20);
        check("t6_mid_frame", txd_a, 0);
        rst_n = 1'b0;
        tick(1);
        check("t6_txd", txd_a, 1);
        check("t6_tc", tc_a, 0);
        check("t6_rc", rc_a, 0);
        check("t6_ready", tx_ready_a, 0);
        check("t6_rv", rv_a, 0);
        check("t6_data", rx_data_a, 0);
        check("t6_ov", ov_a, 0);
        rst_n = 1'b1;
        tick(2);
        check("t6_txd_idle", txd_a, 1);
        send_bit(0, 1'b0, 4);
        send_bit(0, 1'b1, 40);
        check("t6_glitch_rc", rc_a, 0);
        check("t6_glitch_rv", rv_a, 0);
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1, OS);
        check("t6_after_glitch", rx_data_a, 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
